pronoc_pck_ejector: RTL and testbench

Endpoint-side receiver that reassembles flits arriving on a router's local output port into whole packets. It is the counterpart of the packet injector. Each VC has its own flit FIFO and reassembler. Credits go back to the router as flits are drained. Completed packets leave through a valid/ready interface, arbitrated round-robin across VCs.

---
 rtl/pronoc_pck_ejector_if.sv | 30 +++
 rtl/pronoc_pck_ejector.sv | 119 +++++++++++
 tb/tb_pronoc_pck_ejector.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pronoc_pck_ejector_if.sv
// pronoc_pck_ejector_if: router-side flit/credit signals and consumer-side packet signals of the ejector.
interface pronoc_pck_ejector_if #(
  parameter int V = 2, B_EJ = 4, Fpay = 32, EAw = 8, Cw = 1, PCK_INJ_Dw = 64, MAX_PCK_SIZ = 16
);
  localparam int CRDw = $clog2(B_EJ + 1);
  localparam int PCK_SIZw = $clog2(MAX_PCK_SIZ + 1);
  logic flit_in_wr, flit_in_hdr, flit_in_tail;
  logic [V-1:0] flit_in_vc;
  logic [Fpay-1:0] flit_in_payload;
  logic [V-1:0] credit_out;
  logic [V*CRDw-1:0] credit_init_val;
  logic pck_valid, pck_ready;
  logic [V-1:0] pck_vc;
  logic [EAw-1:0] pck_src_e_addr;
  logic [Cw-1:0] pck_class;
  logic [PCK_INJ_Dw-1:0] pck_data;
  logic [PCK_SIZw-1:0] pck_size;
  logic [15:0] pck_h2t_delay;
  logic [2:0] err_flags;
  modport master (
    output flit_in_wr, flit_in_hdr, flit_in_tail, flit_in_vc, flit_in_payload, pck_ready,
    input credit_out, credit_init_val, pck_valid, pck_vc, pck_src_e_addr, pck_class, pck_data,
          pck_size, pck_h2t_delay, err_flags
  );
  modport slave (
    input flit_in_wr, flit_in_hdr, flit_in_tail, flit_in_vc, flit_in_payload, pck_ready,
    output credit_out, credit_init_val, pck_valid, pck_vc, pck_src_e_addr, pck_class, pck_data,
           pck_size, pck_h2t_delay, err_flags
  );
endinterface

// File: rtl/pronoc_pck_ejector.sv
// pronoc_pck_ejector: per-VC flit FIFOs and packet reassembly with credit return and round-robin packet output.
// Define PRONOC_EJ_H2T_DELAY_EN to measure the header-to-tail drain delay of each packet.
module pronoc_pck_ejector #(
  parameter int V = 2, B_EJ = 4, Fpay = 32, EAw = 8, Cw = 1, PCK_INJ_Dw = 64, MAX_PCK_SIZ = 16
) (
  input logic clk,
  input logic reset,
  pronoc_pck_ejector_if.slave bus
);
  localparam int CRDw = $clog2(B_EJ + 1);
  localparam int PCK_SIZw = $clog2(MAX_PCK_SIZ + 1);
  localparam int Aw = B_EJ > 1 ? $clog2(B_EJ) : 1;
  localparam int Vw = V > 1 ? $clog2(V) : 1;
  localparam int Fw = Fpay + 2;
  localparam int NSLOT = PCK_INJ_Dw / Fpay;
  typedef enum logic [1:0] {IDLE, ASM, DONE} st_e;
  st_e st_q [V], st_d [V];
  logic [Fw-1:0] mem_q [V][B_EJ], mem_d [V][B_EJ];
  logic [Aw-1:0] rp_q [V], rp_d [V], wp_q [V], wp_d [V];
  logic [CRDw-1:0] cnt_q [V], cnt_d [V];
  logic [EAw-1:0] src_q [V], src_d [V];
  logic [Cw-1:0] cls_q [V], cls_d [V];
  logic [PCK_INJ_Dw-1:0] data_q [V], data_d [V];
  logic [PCK_SIZw-1:0] size_q [V], size_d [V];
  logic [V-1:0] credit_q, credit_d, pop;
  logic [2:0] err_q, err_d;
  logic [Vw-1:0] rr_q, rr_d, gnt;
  logic found, push, hdr, tail;
  logic [Fpay-1:0] pl;
`ifdef PRONOC_EJ_H2T_DELAY_EN
  logic [15:0] tick_q, tick_d, hts_q [V], hts_d [V], h2t_q [V], h2t_d [V];
`endif
  always_comb begin
    st_d = st_q; mem_d = mem_q; rp_d = rp_q; wp_d = wp_q; cnt_d = cnt_q;
    src_d = src_q; cls_d = cls_q; data_d = data_q; size_d = size_q;
    err_d = err_q; rr_d = rr_q; pop = '0; push = 1'b0; hdr = 1'b0; tail = 1'b0; pl = '0;
    gnt = '0; found = 1'b0;
`ifdef PRONOC_EJ_H2T_DELAY_EN
    tick_d = tick_q + 16'd1; hts_d = hts_q; h2t_d = h2t_q;
`endif
    for (int i = 0; i < V; i++) begin
      if (!found && st_q[(int'(rr_q) + i) % V] == DONE) begin
        found = 1'b1;
        gnt = Vw'((int'(rr_q) + i) % V);
      end
    end
    for (int v = 0; v < V; v++) begin
      push = bus.flit_in_wr && bus.flit_in_vc[v];
      pop[v] = cnt_q[v] != '0 && st_q[v] != DONE;
      {hdr, tail, pl} = mem_q[v][rp_q[v]];
      if (push && cnt_q[v] == CRDw'(B_EJ)) err_d[0] = 1'b1;
      push = push && cnt_q[v] != CRDw'(B_EJ);
      if (push) mem_d[v][wp_q[v]] = {bus.flit_in_hdr, bus.flit_in_tail, bus.flit_in_payload};
      if (push) wp_d[v] = wp_q[v] == Aw'(B_EJ - 1) ? '0 : wp_q[v] + 1'b1;
      if (pop[v]) rp_d[v] = rp_q[v] == Aw'(B_EJ - 1) ? '0 : rp_q[v] + 1'b1;
      cnt_d[v] = cnt_q[v] + CRDw'(push) - CRDw'(pop[v]);
      if (pop[v] && hdr) begin
        if (st_q[v] == ASM) err_d[2] = 1'b1;
        src_d[v] = pl[EAw-1:0];
        cls_d[v] = pl[2*EAw+Cw-1:2*EAw];
        size_d[v] = PCK_SIZw'(1);
        data_d[v] = '0;
        st_d[v] = tail ? DONE : ASM;
`ifdef PRONOC_EJ_H2T_DELAY_EN
        hts_d[v] = tick_q;
        h2t_d[v] = '0;
`endif
      end else if (pop[v] && st_q[v] == IDLE) begin
        err_d[1] = 1'b1;
      end else if (pop[v]) begin
        // body index is size-1; slots past the data width are simply not written
        for (int j = 0; j < NSLOT; j++)
          if (int'(size_q[v]) == j + 1) data_d[v][j*Fpay +: Fpay] = pl;
        if (size_q[v] != PCK_SIZw'(MAX_PCK_SIZ)) size_d[v] = size_q[v] + PCK_SIZw'(1);
        if (tail) st_d[v] = DONE;
`ifdef PRONOC_EJ_H2T_DELAY_EN
        if (tail) h2t_d[v] = tick_q - hts_q[v];
`endif
      end
      if (found && bus.pck_ready && int'(gnt) == v) begin
        st_d[v] = IDLE; src_d[v] = '0; cls_d[v] = '0; data_d[v] = '0; size_d[v] = '0;
      end
    end
    if (found && bus.pck_ready) rr_d = int'(gnt) == V - 1 ? '0 : gnt + 1'b1;
    credit_d = pop;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '{default: IDLE}; mem_q <= '{default: '0}; rp_q <= '{default: '0};
      wp_q <= '{default: '0}; cnt_q <= '{default: '0}; src_q <= '{default: '0};
      cls_q <= '{default: '0}; data_q <= '{default: '0}; size_q <= '{default: '0};
      credit_q <= '0; err_q <= '0; rr_q <= '0;
`ifdef PRONOC_EJ_H2T_DELAY_EN
      tick_q <= '0; hts_q <= '{default: '0}; h2t_q <= '{default: '0};
`endif
    end else begin
      st_q <= st_d; mem_q <= mem_d; rp_q <= rp_d; wp_q <= wp_d; cnt_q <= cnt_d;
      src_q <= src_d; cls_q <= cls_d; data_q <= data_d; size_q <= size_d;
      credit_q <= credit_d; err_q <= err_d; rr_q <= rr_d;
`ifdef PRONOC_EJ_H2T_DELAY_EN
      tick_q <= tick_d; hts_q <= hts_d; h2t_q <= h2t_d;
`endif
    end
  end
  assign bus.credit_out = credit_q;
  assign bus.credit_init_val = {V{CRDw'(B_EJ)}};
  assign bus.err_flags = err_q;
  assign bus.pck_valid = found;
  assign bus.pck_vc = found ? V'(1) << gnt : '0;
  assign bus.pck_src_e_addr = found ? src_q[gnt] : '0;
  assign bus.pck_class = found ? cls_q[gnt] : '0;
  assign bus.pck_data = found ? data_q[gnt] : '0;
  assign bus.pck_size = found ? size_q[gnt] : '0;
`ifdef PRONOC_EJ_H2T_DELAY_EN
  assign bus.pck_h2t_delay = found ? h2t_q[gnt] : '0;
`else
  assign bus.pck_h2t_delay = '0;
`endif
endmodule

// File: tb/tb_pronoc_pck_ejector.sv
// tb_pronoc_pck_ejector: cycle-by-cycle vector table for pronoc_pck_ejector plus reset and latency sequences.
module tb_pronoc_pck_ejector;
`ifdef PRONOC_EJ_H2T_DELAY_EN
  localparam int H2T_EN = 1;
`else
  localparam int H2T_EN = 0;
`endif
  localparam int N = 0, H = 1, B = 2, T = 3, S = 4;
  typedef struct {
    logic wr, hdr, tail;
    logic [1:0] vc;
    logic [31:0] pl;
    logic rdy, ev;
    logic [1:0] evc;
    logic [63:0] ed;
    logic [4:0] esz;
    logic [7:0] esrc;
    logic ecls;
    logic [15:0] eh2t;
    logic [1:0] ecr;
    logic [2:0] eerr;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  int n_vec = 0, n_err = 0, lat;
  vec_t tv[$];
  pronoc_pck_ejector_if bus ();
  pronoc_pck_ejector dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic vec_t mk(int f, logic [1:0] vc, logic [31:0] pl, logic rdy, logic ev,
      logic [1:0] evc, logic [63:0] ed, int esz, logic [7:0] esrc, logic ecls, int eh2t,
      logic [1:0] ecr, logic [2:0] eerr);
    vec_t r;
    r.wr = f != N; r.hdr = f == H || f == S; r.tail = f == T || f == S;
    r.vc = vc; r.pl = pl; r.rdy = rdy; r.ev = ev; r.evc = evc; r.ed = ed;
    r.esz = 5'(esz); r.esrc = esrc; r.ecls = ecls; r.eh2t = 16'(eh2t); r.ecr = ecr; r.eerr = eerr;
    return r;
  endfunction
  function automatic vec_t mki(int f, logic [1:0] vc, logic [31:0] pl, logic rdy, logic [1:0] ecr,
      logic [2:0] eerr);
    return mk(f, vc, pl, rdy, 0, 0, 0, 0, 0, 0, 0, ecr, eerr);
  endfunction
  function automatic int e(int x);
    return x * H2T_EN;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.flit_in_wr = 0; bus.flit_in_hdr = 0; bus.flit_in_tail = 0;
    bus.flit_in_vc = 0; bus.flit_in_payload = 0; bus.pck_ready = 0;
  endtask
  task automatic chk_zero(string tag);
    chk({tag, " valid"}, bus.pck_valid, 0);
    chk({tag, " credit"}, bus.credit_out, 0);
    chk({tag, " err"}, bus.err_flags, 0);
    chk({tag, " data"}, bus.pck_data, 0);
    chk({tag, " size"}, bus.pck_size, 0);
    chk({tag, " src"}, bus.pck_src_e_addr, 0);
    chk({tag, " vc"}, bus.pck_vc, 0);
  endtask

  initial begin
    // 4-flit packet on VC0
    tv.push_back(mki(H, 2'b01, 32'h0001_0012, 1, 2'b00, 3'b000));
    tv.push_back(mki(B, 2'b01, 32'hAAAA_0001, 1, 2'b00, 3'b000));
    tv.push_back(mki(B, 2'b01, 32'hBBBB_0002, 1, 2'b01, 3'b000));
    tv.push_back(mki(T, 2'b01, 32'hCCCC_0003, 1, 2'b01, 3'b000));
    tv.push_back(mki(N, 2'b00, 0, 1, 2'b01, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b01, 64'hBBBB0002_AAAA0001, 4, 8'h12, 1, e(3), 2'b01, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b00, 3'b000));
    // single-flit packet on VC1
    tv.push_back(mki(S, 2'b10, 32'h34, 1, 2'b00, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b00, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b10, 0, 1, 8'h34, 0, 0, 2'b10, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b00, 3'b000));
    // round robin: both DONE, pointer at VC0
    tv.push_back(mki(S, 2'b01, 32'h61, 0, 2'b00, 3'b000));
    tv.push_back(mki(S, 2'b10, 32'h0001_0062, 0, 2'b00, 3'b000));
    tv.push_back(mk(N, 0, 0, 0, 1, 2'b01, 0, 1, 8'h61, 0, 0, 2'b01, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b01, 0, 1, 8'h61, 0, 0, 2'b10, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b10, 0, 1, 8'h62, 1, 0, 2'b00, 3'b000));
    tv.push_back(mki(S, 2'b10, 32'h63, 0, 2'b00, 3'b000));
    tv.push_back(mki(S, 2'b01, 32'h64, 0, 2'b00, 3'b000));
    tv.push_back(mk(N, 0, 0, 0, 1, 2'b10, 0, 1, 8'h63, 0, 0, 2'b10, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b01, 0, 1, 8'h64, 0, 0, 2'b01, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b10, 0, 1, 8'h63, 0, 0, 2'b00, 3'b000));
    tv.push_back(mki(N, 0, 0, 0, 2'b00, 3'b000));
    // backpressure: 2-flit packet then 4 more flits with ready low
    tv.push_back(mki(H, 2'b01, 32'h56, 0, 2'b00, 3'b000));
    tv.push_back(mki(T, 2'b01, 32'h1111_1111, 0, 2'b00, 3'b000));
    tv.push_back(mki(H, 2'b01, 32'h57, 0, 2'b01, 3'b000));
    tv.push_back(mk(B, 2'b01, 32'h2222_2222, 0, 1, 2'b01, 64'h11111111, 2, 8'h56, 0, e(1), 2'b01, 3'b000));
    tv.push_back(mk(B, 2'b01, 32'h3333_3333, 0, 1, 2'b01, 64'h11111111, 2, 8'h56, 0, e(1), 2'b00, 3'b000));
    tv.push_back(mk(T, 2'b01, 32'h4444_4444, 0, 1, 2'b01, 64'h11111111, 2, 8'h56, 0, e(1), 2'b00, 3'b000));
    tv.push_back(mk(N, 0, 0, 0, 1, 2'b01, 64'h11111111, 2, 8'h56, 0, e(1), 2'b00, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b01, 64'h11111111, 2, 8'h56, 0, e(1), 2'b00, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b00, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b01, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b01, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b01, 3'b000));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b01, 64'h33333333_22222222, 4, 8'h57, 0, e(3), 2'b01, 3'b000));
    tv.push_back(mki(N, 0, 0, 1, 2'b00, 3'b000));
    // orphan body, then header aborting a packet
    tv.push_back(mki(B, 2'b01, 32'hDEAD_0000, 1, 2'b00, 3'b000));
    tv.push_back(mki(H, 2'b01, 32'h71, 1, 2'b00, 3'b000));
    tv.push_back(mki(B, 2'b01, 32'h5555_5555, 1, 2'b01, 3'b010));
    tv.push_back(mki(H, 2'b01, 32'h0001_0072, 1, 2'b01, 3'b010));
    tv.push_back(mki(T, 2'b01, 32'h6666_6666, 1, 2'b01, 3'b010));
    tv.push_back(mki(N, 0, 0, 1, 2'b01, 3'b110));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b01, 64'h66666666, 2, 8'h72, 1, e(1), 2'b01, 3'b110));
    tv.push_back(mki(N, 0, 0, 0, 2'b00, 3'b110));
    // overflow: VC0 held in DONE while its FIFO fills, 5th write dropped
    tv.push_back(mki(S, 2'b01, 32'h81, 0, 2'b00, 3'b110));
    tv.push_back(mki(H, 2'b01, 32'h82, 0, 2'b00, 3'b110));
    tv.push_back(mk(B, 2'b01, 32'h1, 0, 1, 2'b01, 0, 1, 8'h81, 0, 0, 2'b01, 3'b110));
    tv.push_back(mk(B, 2'b01, 32'h2, 0, 1, 2'b01, 0, 1, 8'h81, 0, 0, 2'b00, 3'b110));
    tv.push_back(mk(T, 2'b01, 32'h3, 0, 1, 2'b01, 0, 1, 8'h81, 0, 0, 2'b00, 3'b110));
    tv.push_back(mk(B, 2'b01, 32'h4, 0, 1, 2'b01, 0, 1, 8'h81, 0, 0, 2'b00, 3'b110));
    tv.push_back(mk(N, 0, 0, 0, 1, 2'b01, 0, 1, 8'h81, 0, 0, 2'b00, 3'b111));
    tv.push_back(mk(N, 0, 0, 1, 1, 2'b01, 0, 1, 8'h81, 0, 0, 2'b00, 3'b111));
    tv.push_back(mki(N, 0, 0, 0, 2'b00, 3'b111));
    tv.push_back(mki(N, 0, 0, 0, 2'b01, 3'b111));

    idle_inputs();
    #1 chk_zero("reset");
    chk("credit_init_val", bus.credit_init_val, 6'b100_100);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (tv[i]) begin
      @(negedge clk);
      bus.flit_in_wr = tv[i].wr; bus.flit_in_hdr = tv[i].hdr; bus.flit_in_tail = tv[i].tail;
      bus.flit_in_vc = tv[i].vc; bus.flit_in_payload = tv[i].pl; bus.pck_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d valid", i), bus.pck_valid, tv[i].ev);
      chk($sformatf("v%0d vc", i), bus.pck_vc, tv[i].evc);
      chk($sformatf("v%0d data", i), bus.pck_data, tv[i].ed);
      chk($sformatf("v%0d size", i), bus.pck_size, tv[i].esz);
      chk($sformatf("v%0d src", i), bus.pck_src_e_addr, tv[i].esrc);
      chk($sformatf("v%0d class", i), bus.pck_class, tv[i].ecls);
      chk($sformatf("v%0d h2t", i), bus.pck_h2t_delay, tv[i].eh2t);
      chk($sformatf("v%0d credit", i), bus.credit_out, tv[i].ecr);
      chk($sformatf("v%0d err", i), bus.err_flags, tv[i].eerr);
    end
    // asynchronous reset while VC0 is mid-packet
    @(negedge clk);
    idle_inputs();
    #1 chk("pre-reset credit", bus.credit_out, 2'b01);
    #2 reset = 1'b1;
    #1 chk_zero("midpkt reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 chk("post-reset credit", bus.credit_out, 0);
      chk("post-reset valid", bus.pck_valid, 0);
    end
    // single-flit latency on VC1, bounded wait
    @(negedge clk);
    bus.flit_in_wr = 1; bus.flit_in_hdr = 1; bus.flit_in_tail = 1;
    bus.flit_in_vc = 2'b10; bus.flit_in_payload = 32'h90;
    #1 chk("lat write valid", bus.pck_valid, 0);
    lat = -1;
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      @(negedge clk);
      bus.flit_in_wr = 0;
      #1 if (bus.pck_valid) lat = n;
    end
    chk("latency", lat, 2);
    chk("lat vc", bus.pck_vc, 2'b10);
    chk("lat size", bus.pck_size, 1);
    chk("lat src", bus.pck_src_e_addr, 8'h90);
    chk("lat credit", bus.credit_out, 2'b10);
    @(negedge clk);
    bus.pck_ready = 1;
    @(negedge clk);
    #1 chk("lat accepted", bus.pck_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
